marker_chk: RTL

Receive-side marker checker for the per-beat user marker bits that a far-end marker generator drives across the link. It derives the expected marker pattern from the configured local and remote rates, hunts for pattern alignment, declares lock after a run of matching beats, and counts marker errors while locked. It sits in the DV receive path beside the data checker and gives the bench alignment and lock status.

---
 rtl/marker_chk_if.sv | 25 ++
 rtl/marker_chk.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/marker_chk_if.sv
// Marker checker bus: received beat, rate configuration, and lock/error status.
interface marker_chk_if #(
    parameter int ERR_CNT_W = 16
);
    logic [3:0]           local_rate;
    logic [3:0]           remote_rate;
    logic                 rx_valid;
    logic [3:0]           rx_marker;
    logic                 clear_err;
    logic                 locked;
    logic                 lock_lost;
    logic                 cfg_err;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic [1:0]           phase;

    modport master (
        output local_rate, remote_rate, rx_valid, rx_marker, clear_err,
        input  locked, lock_lost, cfg_err, err_cnt, phase
    );

    modport slave (
        input  local_rate, remote_rate, rx_valid, rx_marker, clear_err,
        output locked, lock_lost, cfg_err, err_cnt, phase
    );
endinterface

// File: rtl/marker_chk.sv
// Receive-side marker checker: hunts for the rate-derived marker pattern,
// declares lock after a run of matches, and counts mismatches while locked.
module marker_chk #(
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4,
    parameter int ERR_CNT_W  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    marker_chk_if.slave bus
);
    localparam logic [3:0] RATE_FULL    = 4'h1;
    localparam logic [3:0] RATE_HALF    = 4'h2;
    localparam logic [3:0] RATE_QUARTER = 4'h4;
    localparam logic [7:0] LOCK_N       = 8'(LOCK_CNT);
    localparam logic [7:0] UNLOCK_N     = 8'(UNLOCK_CNT);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    function automatic logic rate_ok(input logic [3:0] r);
        return (r == RATE_FULL) || (r == RATE_HALF) || (r == RATE_QUARTER);
    endfunction

    function automatic logic [3:0] width_mask(input logic [3:0] l);
        logic [3:0] m;
        case (l)
            RATE_FULL: m = 4'b0001;
            RATE_HALF: m = 4'b0011;
            default:   m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] expected(input logic [3:0] l, input logic [3:0] r,
                                            input logic [1:0] p);
        logic [3:0] e;
        e = 4'b0000;
        case (l)
            RATE_FULL: begin
                case (r)
                    RATE_FULL: e = 4'b0001;
                    RATE_HALF: e = {3'b000, p[0]};
                    default:   e = {3'b000, &p};
                endcase
            end
            RATE_HALF: begin
                case (r)
                    RATE_FULL: e = 4'b0011;
                    RATE_HALF: e = 4'b0010;
                    default:   e = {2'b00, p[0], 1'b0};
                endcase
            end
            default: begin
                case (r)
                    RATE_FULL: e = 4'b1111;
                    RATE_HALF: e = 4'b1010;
                    default:   e = 4'b1000;
                endcase
            end
        endcase
        return e;
    endfunction

    state_t               state_q;
    logic [3:0]           lrate_q, rrate_q;
    logic [7:0]           good_q, bad_q;
    logic [1:0]           phase_q;
    logic                 locked_q, lost_q, cfg_err_q;
    logic [ERR_CNT_W-1:0] err_q;

    logic       rate_chg, cfg_bad, match;
    logic [1:0] exp_phase;
    logic [7:0] good_inc, bad_inc;

    assign rate_chg  = (lrate_q != bus.local_rate) || (rrate_q != bus.remote_rate);
    assign cfg_bad   = !(rate_ok(bus.local_rate) && rate_ok(bus.remote_rate));
    // While hunting, the anchor is the last beat of the pattern period.
    assign exp_phase = (state_q == HUNT) ? 2'd3 : phase_q;
    assign match     = ((bus.rx_marker ^ expected(bus.local_rate, bus.remote_rate, exp_phase))
                        & width_mask(bus.local_rate)) == 4'b0000;
    assign good_inc  = good_q + 8'd1;
    assign bad_inc   = bad_q + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            lrate_q   <= 4'h0;
            rrate_q   <= 4'h0;
            good_q    <= 8'd0;
            bad_q     <= 8'd0;
            phase_q   <= 2'd0;
            locked_q  <= 1'b0;
            lost_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            err_q     <= '0;
        end else begin
            lrate_q   <= bus.local_rate;
            rrate_q   <= bus.remote_rate;
            cfg_err_q <= cfg_bad;
            lost_q    <= 1'b0;
            if (rate_chg || cfg_bad) begin
                state_q  <= HUNT;
                good_q   <= 8'd0;
                bad_q    <= 8'd0;
                phase_q  <= 2'd0;
                locked_q <= 1'b0;
            end else if (bus.rx_valid) begin
                case (state_q)
                    HUNT: begin
                        if (match) begin
                            good_q  <= 8'd1;
                            phase_q <= 2'd0;
                            if (LOCK_N == 8'd1) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end else begin
                                state_q <= VERIFY;
                            end
                        end
                    end
                    VERIFY: begin
                        if (match) begin
                            good_q  <= good_inc;
                            phase_q <= phase_q + 2'd1;
                            if (good_inc == LOCK_N) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end
                        end else begin
                            state_q <= HUNT;
                            good_q  <= 8'd0;
                            phase_q <= 2'd0;
                        end
                    end
                    LOCKED: begin
                        phase_q <= phase_q + 2'd1;
                        if (match) begin
                            bad_q <= 8'd0;
                        end else begin
                            bad_q <= bad_inc;
                            if (!(&err_q)) err_q <= err_q + 1'b1;
                            if (bad_inc == UNLOCK_N) begin
                                state_q  <= HUNT;
                                bad_q    <= 8'd0;
                                phase_q  <= 2'd0;
                                locked_q <= 1'b0;
                                lost_q   <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q  <= HUNT;
                        good_q   <= 8'd0;
                        bad_q    <= 8'd0;
                        phase_q  <= 2'd0;
                        locked_q <= 1'b0;
                    end
                endcase
            end
            // A same-cycle clear overrides any increment above.
            if (bus.clear_err) err_q <= '0;
        end
    end

    assign bus.locked    = locked_q;
    assign bus.lock_lost = lost_q;
    assign bus.cfg_err   = cfg_err_q;
    assign bus.err_cnt   = err_q;
    assign bus.phase     = phase_q;
endmodule
